// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and helpers for the multi-cycle shift/rotate unit.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [2:0] {
        SLL  = 3'd0,
        SRL  = 3'd1,
        SRA  = 3'd2,
        ROL  = 3'd3,
        ROR  = 3'd4,
        PASS = 3'd5
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

    localparam int c_def_width      = 16;
    localparam int c_def_log2_width = $clog2(c_def_width);

    function automatic int log2_width(input int width);
        return $clog2(width);
    endfunction

    // Codes 5..7 all collapse onto PASS.
    function automatic shift_op_t decode_op(input logic [2:0] code);
        shift_op_t r;
        case (code)
            3'd0:    r = SLL;
            3'd1:    r = SRL;
            3'd2:    r = SRA;
            3'd3:    r = ROL;
            3'd4:    r = ROR;
            default: r = PASS;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : One combinational shift/rotate step of up to STEP positions.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]           v,
    input  logic [$clog2(STEP+1)-1:0]  k,
    input  shift_op_t                  op,
    input  logic                       sign,
    output logic [WIDTH-1:0]           v_next,
    output logic                       c_out
);

    localparam int               c_k_w   = $clog2(STEP + 1);
    localparam int               c_kc_w  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] c_ones  = '1;
    localparam logic [WIDTH-1:0] c_lsb   = WIDTH'(1);
    localparam logic [c_k_w-1:0] c_k_one = c_k_w'(1);

    logic [c_k_w-1:0]  w_km1;
    logic [c_kc_w-1:0] w_kc;
    logic [WIDTH-1:0]  w_fill;
    logic              w_c_low;
    logic              w_c_high;

    assign w_km1 = k - c_k_one;
    assign w_kc  = c_kc_w'(WIDTH) - c_kc_w'(k);

    // SRA fill comes from the operand's original sign, not the current MSB.
    assign w_fill   = sign ? ~(c_ones >> k) : '0;
    assign w_c_low  = |(v & (c_lsb << w_km1));
    assign w_c_high = |(v & (c_lsb << w_kc));

    always_comb begin
        v_next = v;
        c_out  = 1'b0;
        case (op)
            SLL: begin
                v_next = v << k;
                c_out  = w_c_high;
            end
            SRL: begin
                v_next = v >> k;
                c_out  = w_c_low;
            end
            SRA: begin
                v_next = (v >> k) | w_fill;
                c_out  = w_c_low;
            end
            ROL: begin
                v_next = (v << k) | (v >> w_kc);
                c_out  = v_next[0];
            end
            ROR: begin
                v_next = (v >> k) | (v << w_kc);
                c_out  = v_next[WIDTH-1];
            end
            default: begin
                v_next = v;
                c_out  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_unit
// Description : Multi-cycle shift/rotate unit with start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout,
    output logic               carry,
    output logic               zero
);

    localparam int                 c_k_w     = $clog2(STEP + 1);
    localparam int                 c_log2_w  = log2_width(WIDTH);
    localparam logic [SHAMT_W-1:0] c_width_s = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] c_step_s  = SHAMT_W'(STEP);

    shift_state_t       r_state;
    shift_state_t       w_state_next;
    logic [WIDTH-1:0]   r_v;
    logic [SHAMT_W-1:0] r_rem;
    shift_op_t          r_op;
    logic               r_sign;
    logic [WIDTH-1:0]   r_dout;
    logic               r_carry;
    logic               r_zero;

    shift_op_t          w_op;
    logic [SHAMT_W-1:0] w_eff;
    logic [SHAMT_W-1:0] w_rot_amt;
    logic               w_accept;
    logic               w_last;
    logic [c_k_w-1:0]   w_k;
    logic [WIDTH-1:0]   w_v_next;
    logic               w_c_step;

    assign w_op      = decode_op(op);
    assign w_rot_amt = {{(SHAMT_W - c_log2_w){1'b0}}, shamt[c_log2_w-1:0]};
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_rem <= c_step_s);
    assign w_k       = (r_rem > c_step_s) ? c_k_w'(STEP) : r_rem[c_k_w-1:0];

    // Shifts saturate at WIDTH; rotates wrap modulo WIDTH.
    always_comb begin
        w_eff = '0;
        case (w_op)
            SLL, SRL, SRA: w_eff = (shamt > c_width_s) ? c_width_s : shamt;
            ROL, ROR:      w_eff = w_rot_amt;
            default:       w_eff = '0;
        endcase
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .v      (r_v),
        .k      (w_k),
        .op     (r_op),
        .sign   (r_sign),
        .v_next (w_v_next),
        .c_out  (w_c_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (w_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_next = (w_eff == '0) ? DONE : SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Visible results only move on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v     <= '0;
            r_rem   <= '0;
            r_op    <= PASS;
            r_sign  <= 1'b0;
            r_dout  <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            r_v    <= din;
            r_rem  <= w_eff;
            r_op   <= w_op;
            r_sign <= din[WIDTH-1];
            if (w_eff == '0) begin
                r_dout  <= din;
                r_carry <= 1'b0;
                r_zero  <= (din == '0);
            end
        end else if (r_state == SHIFT) begin
            r_v   <= w_v_next;
            r_rem <= r_rem - SHAMT_W'(w_k);
            if (w_last) begin
                r_dout  <= w_v_next;
                r_carry <= w_c_step;
                r_zero  <= (w_v_next == '0);
            end
        end
    end

    assign dout  = r_dout;
    assign carry = r_carry;
    assign zero  = r_zero;

endmodule
`default_nettype wire
